// File: rtl/vga_pkg.sv
// Shared types and constants for the video SRAM read bridge.
package vga_pkg;

    localparam logic [31:0] VIDMEM_DEFAULT = 32'h00c00000;
    localparam int unsigned SRAM_AW        = 20;
    localparam int unsigned OFF_W          = SRAM_AW - 1;
    localparam int unsigned WAIT_W         = 3;
    localparam int unsigned PIX_W          = 24;
    localparam int unsigned HW_W           = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LO    = 3'd1,
        ST_HI    = 3'd2,
        ST_DONE  = 3'd3,
        ST_PF_LO = 3'd4,
        ST_PF_HI = 3'd5
    } state_e;

    // Pixel word address lies inside the 2^19-pixel window starting at base.
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
        return (addr - base) < (32'd1 << OFF_W);
    endfunction

    // SRAM halfword address of the low (hi=0) or high (hi=1) half of a pixel.
    function automatic logic [SRAM_AW-1:0] hw_addr(input logic [31:0] addr,
                                                   input logic [31:0] base,
                                                   input logic        hi);
        return {OFF_W'(addr - base), hi};
    endfunction

    // {R,G,B}: red from the low byte of the high half, G:B from the low half.
    function automatic logic [PIX_W-1:0] pack_pixel(input logic [7:0]      red,
                                                    input logic [HW_W-1:0] green_blue);
        return {red, green_blue};
    endfunction

endpackage

// File: rtl/vga_sram_phase.sv
// Halfword phase timer: strobes on the last cycle an SRAM address is held.
module vga_sram_phase
    import vga_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic vga_clock,
    input  logic reset_n,
    input  logic active,
    input  logic restart,
    output logic sample_c
);

    localparam logic [WAIT_W-1:0] LAST = WAIT_W'(WAIT_CYCLES);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    assign sample_c = active && (cnt_q == LAST);

    // Count held cycles; rewind at phase end, when idle, or on an aborted phase.
    always_comb begin
        cnt_d = cnt_q;
        if (restart || !active || sample_c) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + WAIT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge vga_clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_sram_bridge.sv
// Framebuffer-fetcher read port onto a 16-bit async video SRAM, with a
// one-entry next-pixel prefetch buffer.
module vga_sram_bridge
    import vga_pkg::*;
#(
    parameter logic [31:0] VIDMEM      = VIDMEM_DEFAULT,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter bit          PREFETCH    = 1'b1
) (
    input  logic               vga_clock,
    input  logic               reset_n,
    input  logic               bus_read,
    input  logic [31:0]        address,
    output logic               bus_wait,
    output logic [PIX_W-1:0]   data,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [HW_W-1:0]    sram_dq,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n
);

    state_e             state_q,      state_d;
    logic [31:0]        req_addr_q,   req_addr_d;
    logic [PIX_W-1:0]   data_q,       data_d;
    logic [HW_W-1:0]    lo_q,         lo_d;
    logic [31:0]        pf_addr_q,    pf_addr_d;
    logic [PIX_W-1:0]   pf_data_q,    pf_data_d;
    logic               pf_valid_q,   pf_valid_d;
    logic               pf_pending_q, pf_pending_d;
    logic               cvt_q,        cvt_d;
    logic               sched_q,      sched_d;
    logic [SRAM_AW-1:0] sram_addr_q,  sram_addr_d;
    logic               sram_ce_n_q,  sram_ce_n_d;

    logic               hit_c;
    logic               active_c;
    logic               restart_c;
    logic               sample_c;
    logic [PIX_W-1:0]   pix_c;
    logic [31:0]        next_addr_c;

    assign hit_c       = pf_valid_q && (address == pf_addr_q);
    assign active_c    = state_q inside {ST_LO, ST_HI, ST_PF_LO, ST_PF_HI};
    assign pix_c       = pack_pixel(sram_dq[7:0], lo_q);
    assign next_addr_c = req_addr_q + 32'd1;

    assign bus_wait  = bus_read && !((state_q == ST_DONE) || ((state_q == ST_IDLE) && hit_c));
    assign data      = ((state_q == ST_IDLE) && hit_c) ? pf_data_q : data_q;
    assign sram_addr = sram_addr_q;
    assign sram_ce_n = sram_ce_n_q;
    assign sram_oe_n = sram_ce_n_q;
    assign sram_we_n = 1'b1;

    vga_sram_phase #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_phase (
        .vga_clock (vga_clock),
        .reset_n   (reset_n),
        .active    (active_c),
        .restart   (restart_c),
        .sample_c  (sample_c)
    );

    // Next-state, request/prefetch bookkeeping, and SRAM pins for the state being entered.
    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        data_d       = data_q;
        lo_d         = lo_q;
        pf_addr_d    = pf_addr_q;
        pf_data_d    = pf_data_q;
        pf_valid_d   = pf_valid_q;
        pf_pending_d = pf_pending_q;
        cvt_d        = cvt_q;
        sched_d      = sched_q;
        restart_c    = 1'b0;
        sram_addr_d  = sram_addr_q;
        sram_ce_n_d  = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (bus_read) begin
                    if (hit_c) begin
                        data_d     = pf_data_q;
                        pf_valid_d = 1'b0;
                        req_addr_d = address;
                        sched_d    = 1'b1;
                        state_d    = ST_DONE;
                    end else if (!in_window(address, VIDMEM)) begin
                        data_d  = '0;
                        sched_d = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        req_addr_d   = address;
                        pf_pending_d = 1'b0;
                        state_d      = ST_LO;
                    end
                end else if (pf_pending_q) begin
                    state_d = ST_PF_LO;
                end
            end
            ST_LO: begin
                if (sample_c) begin
                    lo_d    = sram_dq;
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                if (sample_c) begin
                    data_d  = pix_c;
                    sched_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!bus_read) begin
                    state_d = ST_IDLE;
                    sched_d = 1'b0;
                    if (sched_q) begin
                        pf_valid_d = 1'b0;
                        if (PREFETCH && in_window(next_addr_c, VIDMEM)) begin
                            pf_addr_d    = next_addr_c;
                            pf_pending_d = 1'b1;
                        end
                    end
                end
            end
            ST_PF_LO, ST_PF_HI: begin
                if (bus_read && !cvt_q && (address != pf_addr_q)) begin
                    // Demand for another pixel: drop the speculative read at once.
                    pf_pending_d = 1'b0;
                    restart_c    = 1'b1;
                    if (in_window(address, VIDMEM)) begin
                        req_addr_d = address;
                        state_d    = ST_LO;
                    end else begin
                        data_d  = '0;
                        sched_d = 1'b0;
                        state_d = ST_DONE;
                    end
                end else begin
                    if (bus_read) begin
                        cvt_d = 1'b1;
                    end
                    if (sample_c) begin
                        if (state_q == ST_PF_LO) begin
                            lo_d    = sram_dq;
                            state_d = ST_PF_HI;
                        end else begin
                            pf_pending_d = 1'b0;
                            cvt_d        = 1'b0;
                            if (cvt_q || bus_read) begin
                                data_d     = pix_c;
                                pf_valid_d = 1'b0;
                                req_addr_d = pf_addr_q;
                                sched_d    = 1'b1;
                                state_d    = ST_DONE;
                            end else begin
                                pf_data_d  = pix_c;
                                pf_valid_d = 1'b1;
                                state_d    = ST_IDLE;
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        unique case (state_d)
            ST_LO: begin
                sram_addr_d = hw_addr(req_addr_d, VIDMEM, 1'b0);
                sram_ce_n_d = 1'b0;
            end
            ST_HI: begin
                sram_addr_d = hw_addr(req_addr_d, VIDMEM, 1'b1);
                sram_ce_n_d = 1'b0;
            end
            ST_PF_LO: begin
                sram_addr_d = hw_addr(pf_addr_d, VIDMEM, 1'b0);
                sram_ce_n_d = 1'b0;
            end
            ST_PF_HI: begin
                sram_addr_d = hw_addr(pf_addr_d, VIDMEM, 1'b1);
                sram_ce_n_d = 1'b0;
            end
            default: begin
                sram_ce_n_d = 1'b1;
            end
        endcase
    end

    // State, datapath and SRAM pin registers.
    always_ff @(posedge vga_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            req_addr_q   <= '0;
            data_q       <= '0;
            lo_q         <= '0;
            pf_addr_q    <= '0;
            pf_data_q    <= '0;
            pf_valid_q   <= 1'b0;
            pf_pending_q <= 1'b0;
            cvt_q        <= 1'b0;
            sched_q      <= 1'b0;
            sram_addr_q  <= '0;
            sram_ce_n_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            data_q       <= data_d;
            lo_q         <= lo_d;
            pf_addr_q    <= pf_addr_d;
            pf_data_q    <= pf_data_d;
            pf_valid_q   <= pf_valid_d;
            pf_pending_q <= pf_pending_d;
            cvt_q        <= cvt_d;
            sched_q      <= sched_d;
            sram_addr_q  <= sram_addr_d;
            sram_ce_n_q  <= sram_ce_n_d;
        end
    end

endmodule

// File: tb/tb_vga_sram_bridge.sv
// Directed bench for vga_sram_bridge with a behavioural async SRAM.
module tb_vga_sram_bridge;

    localparam logic [31:0] VIDMEM = 32'h00c00000;

    logic        vga_clock = 1'b0;
    logic        reset_n;
    logic        bus_read;
    logic [31:0] address;
    logic        bus_wait;
    logic [23:0] data;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;

    int n_pass  = 0;
    int n_total = 0;

    always #5 vga_clock = ~vga_clock;

    vga_sram_bridge #(
        .VIDMEM      (VIDMEM),
        .WAIT_CYCLES (1),
        .PREFETCH    (1'b1)
    ) dut (
        .vga_clock (vga_clock),
        .reset_n   (reset_n),
        .bus_read  (bus_read),
        .address   (address),
        .bus_wait  (bus_wait),
        .data      (data),
        .sram_addr (sram_addr),
        .sram_dq   (sram_dq),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n)
    );

    // SRAM contents: two fixed halfwords, the rest a simple address pattern.
    always_comb begin
        if (sram_ce_n || sram_oe_n)  sram_dq = 16'hDEAD;
        else if (sram_addr == 20'd10) sram_dq = 16'h3344;
        else if (sram_addr == 20'd11) sram_dq = 16'hAA12;
        else sram_dq = sram_addr[15:0] ^ 16'hF0F0 ^ {12'h000, sram_addr[19:16]};
    end

    task automatic tick();
        @(posedge vga_clock);
        #1;
    endtask

    task automatic apply_reset();
        bus_read = 1'b0;
        address  = '0;
        reset_n  = 1'b0;
        tick();
        reset_n  = 1'b1;
    endtask

    // Hold a request until bus_wait falls (bounded); returns wait cycles and pixel.
    task automatic fetch(input logic [31:0] a, output int lat, output logic [23:0] d);
        address  = a;
        bus_read = 1'b1;
        lat      = 0;
        @(negedge vga_clock);
        while (bus_wait !== 1'b0 && lat < 20) begin
            lat++;
            tick();
            @(negedge vga_clock);
        end
        d = data;
        tick();
        bus_read = 1'b0;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        bus_read = 1'b0;
        address  = '0;
        @(negedge vga_clock);
        n_total++; if (bus_wait !== 1'b0) $display("FAIL reset_bus_wait got %b want 0", bus_wait); else n_pass++;
        n_total++; if (data !== 24'h0) $display("FAIL reset_data got %h want 000000", data); else n_pass++;
        n_total++; if (sram_addr !== 20'h0) $display("FAIL reset_sram_addr got %h want 00000", sram_addr); else n_pass++;
        n_total++; if (sram_ce_n !== 1'b1) $display("FAIL reset_ce_n got %b want 1", sram_ce_n); else n_pass++;
        n_total++; if (sram_oe_n !== 1'b1) $display("FAIL reset_oe_n got %b want 1", sram_oe_n); else n_pass++;
        n_total++; if (sram_we_n !== 1'b1) $display("FAIL reset_we_n got %b want 1", sram_we_n); else n_pass++;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_demand();
        logic [19:0] exp_a;
        apply_reset();
        address  = VIDMEM + 32'd5;
        bus_read = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge vga_clock);
            n_total++; if (bus_wait !== 1'b1) $display("FAIL demand_wait_c%0d got %b want 1", k, bus_wait); else n_pass++;
            if (k > 0) begin
                exp_a = (k < 3) ? 20'd10 : 20'd11;
                n_total++; if (sram_addr !== exp_a) $display("FAIL demand_addr_c%0d got %0d want %0d", k, sram_addr, exp_a); else n_pass++;
                n_total++; if (sram_ce_n !== 1'b0) $display("FAIL demand_ce_c%0d got %b want 0", k, sram_ce_n); else n_pass++;
            end
            tick();
        end
        @(negedge vga_clock);
        n_total++; if (bus_wait !== 1'b0) $display("FAIL demand_done_wait got %b want 0", bus_wait); else n_pass++;
        n_total++; if (data !== 24'h123344) $display("FAIL demand_data got %h want 123344", data); else n_pass++;
        n_total++; if (sram_ce_n !== 1'b1) $display("FAIL demand_done_ce got %b want 1", sram_ce_n); else n_pass++;
        tick();
        bus_read = 1'b0;
    endtask

    task automatic test_prefetch_hit();
        int          lat;
        logic [23:0] d;
        apply_reset();
        fetch(VIDMEM + 32'd5, lat, d);
        n_total++; if (lat !== 5) $display("FAIL hit_setup_latency got %0d want 5", lat); else n_pass++;
        n_total++; if (d !== 24'h123344) $display("FAIL hit_setup_data got %h want 123344", d); else n_pass++;
        repeat (6) tick();
        address  = VIDMEM + 32'd6;
        bus_read = 1'b1;
        @(negedge vga_clock);
        n_total++; if (bus_wait !== 1'b0) $display("FAIL hit_wait got %b want 0", bus_wait); else n_pass++;
        n_total++; if (data !== 24'hFDF0FC) $display("FAIL hit_data got %h want fdf0fc", data); else n_pass++;
        n_total++; if (sram_ce_n !== 1'b1) $display("FAIL hit_ce got %b want 1", sram_ce_n); else n_pass++;
        tick();
        bus_read = 1'b0;
    endtask

    task automatic test_prefetch_abort();
        int          lat;
        logic [23:0] d;
        apply_reset();
        fetch(VIDMEM + 32'd5, lat, d);
        tick();
        tick();
        address  = VIDMEM + 32'd100;
        bus_read = 1'b1;
        @(negedge vga_clock);
        n_total++; if (sram_addr !== 20'd12) $display("FAIL abort_pf_addr got %0d want 12", sram_addr); else n_pass++;
        n_total++; if (bus_wait !== 1'b1) $display("FAIL abort_wait got %b want 1", bus_wait); else n_pass++;
        lat = 1;
        tick();
        @(negedge vga_clock);
        n_total++; if (sram_addr !== 20'd200) $display("FAIL abort_new_addr got %0d want 200", sram_addr); else n_pass++;
        while (bus_wait !== 1'b0 && lat < 20) begin
            lat++;
            tick();
            @(negedge vga_clock);
        end
        n_total++; if (lat !== 5) $display("FAIL abort_latency got %0d want 5", lat); else n_pass++;
        n_total++; if (data !== 24'h39F038) $display("FAIL abort_data got %h want 39f038", data); else n_pass++;
        tick();
        bus_read = 1'b0;
    endtask

    task automatic test_prefetch_convert();
        int          lat;
        logic [23:0] d;
        apply_reset();
        fetch(VIDMEM + 32'd5, lat, d);
        repeat (4) tick();
        address  = VIDMEM + 32'd6;
        bus_read = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge vga_clock);
            n_total++; if (bus_wait !== 1'b1) $display("FAIL convert_wait_c%0d got %b want 1", k, bus_wait); else n_pass++;
            n_total++; if (sram_addr !== 20'd13) $display("FAIL convert_addr_c%0d got %0d want 13", k, sram_addr); else n_pass++;
            tick();
        end
        @(negedge vga_clock);
        n_total++; if (bus_wait !== 1'b0) $display("FAIL convert_done_wait got %b want 0", bus_wait); else n_pass++;
        n_total++; if (data !== 24'hFDF0FC) $display("FAIL convert_data got %h want fdf0fc", data); else n_pass++;
        n_total++; if (sram_ce_n !== 1'b1) $display("FAIL convert_ce got %b want 1", sram_ce_n); else n_pass++;
        tick();
        bus_read = 1'b0;
    endtask

    task automatic test_out_of_range();
        int          lat;
        int          lows;
        logic [23:0] d;
        apply_reset();
        fetch(VIDMEM + 32'h0007FFFF, lat, d);
        n_total++; if (lat !== 5) $display("FAIL edge_latency got %0d want 5", lat); else n_pass++;
        n_total++; if (d !== 24'h000F01) $display("FAIL edge_data got %h want 000f01", d); else n_pass++;
        lows = 0;
        repeat (10) begin
            @(negedge vga_clock);
            if (sram_ce_n !== 1'b1) lows++;
            tick();
        end
        n_total++; if (lows !== 0) $display("FAIL edge_no_prefetch got %0d active cycles want 0", lows); else n_pass++;
        address  = 32'h00000010;
        bus_read = 1'b1;
        @(negedge vga_clock);
        n_total++; if (bus_wait !== 1'b1) $display("FAIL oor_wait_c0 got %b want 1", bus_wait); else n_pass++;
        n_total++; if (sram_ce_n !== 1'b1) $display("FAIL oor_ce_c0 got %b want 1", sram_ce_n); else n_pass++;
        tick();
        @(negedge vga_clock);
        n_total++; if (bus_wait !== 1'b0) $display("FAIL oor_wait_c1 got %b want 0", bus_wait); else n_pass++;
        n_total++; if (data !== 24'h0) $display("FAIL oor_data got %h want 000000", data); else n_pass++;
        n_total++; if (sram_ce_n !== 1'b1) $display("FAIL oor_ce_c1 got %b want 1", sram_ce_n); else n_pass++;
        tick();
        bus_read = 1'b0;
        tick();
        fetch(VIDMEM + 32'h00080000, lat, d);
        n_total++; if (lat !== 1) $display("FAIL oor_top_latency got %0d want 1", lat); else n_pass++;
        n_total++; if (d !== 24'h0) $display("FAIL oor_top_data got %h want 000000", d); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int          lat;
        logic [23:0] d;
        apply_reset();
        fetch(VIDMEM + 32'd5, lat, d);
        repeat (6) tick();
        address  = VIDMEM + 32'd20;
        bus_read = 1'b1;
        repeat (3) tick();
        @(negedge vga_clock);
        n_total++; if (sram_addr !== 20'd41) $display("FAIL midrst_in_hi got %0d want 41", sram_addr); else n_pass++;
        reset_n  = 1'b0;
        bus_read = 1'b0;
        tick();
        @(negedge vga_clock);
        n_total++; if (bus_wait !== 1'b0) $display("FAIL midrst_wait got %b want 0", bus_wait); else n_pass++;
        n_total++; if (sram_ce_n !== 1'b1) $display("FAIL midrst_ce got %b want 1", sram_ce_n); else n_pass++;
        n_total++; if (data !== 24'h0) $display("FAIL midrst_data got %h want 000000", data); else n_pass++;
        reset_n = 1'b1;
        tick();
        fetch(VIDMEM + 32'd6, lat, d);
        n_total++; if (lat !== 5) $display("FAIL midrst_refetch_latency got %0d want 5", lat); else n_pass++;
        n_total++; if (d !== 24'hFDF0FC) $display("FAIL midrst_refetch_data got %h want fdf0fc", d); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_demand();
        test_prefetch_hit();
        test_prefetch_abort();
        test_prefetch_convert();
        test_out_of_range();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
